// File: rtl/wordle_board.sv
// wordle_board: keystroke-driven Wordle engine that keeps the registered 6x5 board image for the VGA renderer.
// Optional red flash on a short-row enter: define WORDLE_INVALID_FLASH_EN.
module wordle_board #(
  parameter logic [4:0] BLANK_CODE = 5'd26,
  parameter int         MAX_ROWS   = 6
) (
  input  logic         dclk,
  input  logic         clr,
  input  logic         new_game,
  input  logic [24:0]  target,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  input  logic         key_bksp,
  input  logic         key_enter,
  output logic [209:0] display,
  output logic         busy,
  output logic         game_won,
  output logic         game_lost
);

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_GREEN,
    ST_YELLOW,
    ST_ADVANCE,
    ST_WON,
    ST_LOST
  } state_t;

  localparam logic [209:0] BLANK_BOARD = {30{{2'b00, BLANK_CODE}}};
  localparam logic [2:0]   LAST_ROW    = 3'(MAX_ROWS - 1);

  state_t         r_state;
  logic [209:0]   r_disp;
  logic [24:0]    r_target;
  logic [2:0]     r_row;
  logic [2:0]     r_col;
  logic [2:0]     r_k;
  logic [4:0]     r_used;
  logic [4:0]     r_green;
  logic           r_busy;
  logic           r_won;
  logic           r_lost;
`ifdef WORDLE_INVALID_FLASH_EN
  logic           r_flash;
`endif

  logic [4:0]     w_green_vec;
  logic [4:0]     w_guess_k;
  logic           w_found;
  logic [2:0]     w_j;

  function automatic logic [7:0] cell_base(input logic [2:0] row, input logic [2:0] col);
    return 8'd35 * {5'd0, row} + 8'd7 * {5'd0, col};
  endfunction

  always_comb begin
    w_green_vec = '0;
    for (int c = 0; c < 5; c++) begin
      w_green_vec[c] = (r_disp[cell_base(r_row, 3'(c)) +: 5] == r_target[5*c +: 5]);
    end
  end

  assign w_guess_k = r_disp[cell_base(r_row, r_k) +: 5];

  // Lowest unclaimed target position holding the letter of column r_k.
  always_comb begin
    w_found = 1'b0;
    w_j     = 3'd0;
    for (int j = 0; j < 5; j++) begin
      if (!w_found && !r_used[j] && (r_target[5*j +: 5] == w_guess_k)) begin
        w_found = 1'b1;
        w_j     = 3'(j);
      end
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state  <= ST_ENTRY;
      r_disp   <= BLANK_BOARD;
      r_target <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_k      <= '0;
      r_used   <= '0;
      r_green  <= '0;
      r_busy   <= 1'b0;
      r_won    <= 1'b0;
      r_lost   <= 1'b0;
`ifdef WORDLE_INVALID_FLASH_EN
      r_flash  <= 1'b0;
`endif
    end else if (new_game) begin
      r_state  <= ST_ENTRY;
      r_disp   <= BLANK_BOARD;
      r_target <= target;
      r_row    <= '0;
      r_col    <= '0;
      r_k      <= '0;
      r_used   <= '0;
      r_green  <= '0;
      r_busy   <= 1'b0;
      r_won    <= 1'b0;
      r_lost   <= 1'b0;
`ifdef WORDLE_INVALID_FLASH_EN
      r_flash  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ENTRY: begin
          if (key_enter) begin
            if (r_col == 3'd5) begin
              r_state <= ST_GREEN;
              r_busy  <= 1'b1;
            end
`ifdef WORDLE_INVALID_FLASH_EN
            else begin
              for (int c = 0; c < 5; c++) begin
                r_disp[cell_base(r_row, 3'(c)) + 8'd5 +: 2] <= 2'd3;
              end
              r_flash <= 1'b1;
            end
`endif
          end else if (key_bksp) begin
            if (r_col != 3'd0) begin
`ifdef WORDLE_INVALID_FLASH_EN
              if (r_flash) begin
                for (int c = 0; c < 5; c++) begin
                  r_disp[cell_base(r_row, 3'(c)) + 8'd5 +: 2] <= 2'd0;
                end
              end
              r_flash <= 1'b0;
`endif
              r_col <= r_col - 3'd1;
              r_disp[cell_base(r_row, r_col - 3'd1) +: 7] <= {2'b00, BLANK_CODE};
            end
          end else if (key_valid) begin
            if ((key_code <= 5'd25) && (r_col < 3'd5)) begin
`ifdef WORDLE_INVALID_FLASH_EN
              // Clear the flash first; the new cell write below takes precedence on its own cell.
              if (r_flash) begin
                for (int c = 0; c < 5; c++) begin
                  r_disp[cell_base(r_row, 3'(c)) + 8'd5 +: 2] <= 2'd0;
                end
              end
              r_flash <= 1'b0;
`endif
              r_col <= r_col + 3'd1;
              r_disp[cell_base(r_row, r_col) +: 7] <= {2'b00, key_code};
            end
          end
        end

        ST_GREEN: begin
          for (int c = 0; c < 5; c++) begin
            r_disp[cell_base(r_row, 3'(c)) + 8'd5 +: 2] <= {1'b0, w_green_vec[c]};
          end
          r_green <= w_green_vec;
          r_used  <= w_green_vec;
          r_k     <= 3'd0;
          r_state <= ST_YELLOW;
        end

        ST_YELLOW: begin
          if (!r_green[r_k] && w_found) begin
            r_disp[cell_base(r_row, r_k) + 8'd5 +: 2] <= 2'd2;
            r_used[w_j] <= 1'b1;
          end
          if (r_k == 3'd4) begin
            r_state <= ST_ADVANCE;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end

        ST_ADVANCE: begin
          r_busy <= 1'b0;
          if (&r_green) begin
            r_state <= ST_WON;
            r_won   <= 1'b1;
          end else if (r_row == LAST_ROW) begin
            r_state <= ST_LOST;
            r_lost  <= 1'b1;
          end else begin
            r_row   <= r_row + 3'd1;
            r_col   <= 3'd0;
            r_state <= ST_ENTRY;
          end
        end

        ST_WON, ST_LOST: begin
        end

        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  assign display   = r_disp;
  assign busy      = r_busy;
  assign game_won  = r_won;
  assign game_lost = r_lost;

endmodule

// File: doc/wordle_board.md
Name: wordle_board

Overview:
- Game-state engine that builds the 210-bit board image consumed by the VGA 640x480 renderer.
- Takes decoded keystrokes (letter, backspace, enter) and a 5-letter target word.
- Holds 6 guess rows x 5 columns.
- On enter, scores the row against the target with Wordle duplicate-letter rules over several cycles, then writes colour codes into the board image.

Parameters:
- BLANK_CODE, 26, letter code for an empty cell (renderer draws nothing).
- MAX_ROWS, 6, number of guesses allowed; legal range 1..6. Rows at or above MAX_ROWS stay blank.

Ports:
- dclk  in  1  system/pixel clock, same domain as the renderer.
- clr  in  1  asynchronous reset, active-high.
- new_game  in  1  one-cycle strobe: clear the board and latch target.
- target  in  25  target word; letter i in [5i+4:5i], i=0 is leftmost, codes 0..25.
- key_valid  in  1  one-cycle strobe: key_code is a letter to append.
- key_code  in  5  letter code 0..25 (A..Z).
- key_bksp  in  1  one-cycle strobe: delete last letter.
- key_enter  in  1  one-cycle strobe: submit current row.
- display  out  210  cell (r,c) at [35r+7c +: 7]; [4:0] letter, [6:5] colour (0 gray, 1 green, 2 yellow, 3 red).
- busy  out  1  high while scoring; keys are ignored.
- game_won  out  1  sticky until new_game or clr.
- game_lost  out  1  sticky until new_game or clr.

Behaviour:
- Reset (clr=1, async):
  - Every cell = {2'd0, BLANK_CODE}.
  - Row = 0, col = 0, state = ENTRY; busy, game_won, game_lost = 0.
  - Latched target = 0 (AAAAA).
- new_game has highest priority and is accepted in any state. Next cycle: same as reset, but target is latched from the port.
- Key priority within one cycle: key_enter > key_bksp > key_valid. Lower-priority strobes in the same cycle are dropped.
- States: ENTRY, GREEN, YELLOW, ADVANCE, WON, LOST.
- ENTRY:
  - key_valid with key_code <= 25 and col < 5: write letter at (row,col), colour 0, col += 1.
  - key_valid with key_code > 25 or col = 5: ignored.
  - key_bksp with col > 0: col -= 1 and that cell becomes blank. With col = 0: ignored.
  - key_enter with col = 5: go to GREEN and set busy = 1.
  - key_enter with col < 5: see Optional Feature.
- GREEN (1 cycle):
  - For each column where the guess letter equals the target letter at the same position: colour = 1, set used[c] and green[c].
  - All other cells of the row take colour 0.
- YELLOW (5 cycles, column k = 0..4 in order):
  - If green[k] is clear, find the lowest target index j with used[j]=0 and target[j] == guess[k].
  - If found: colour(k) = 2 and set used[j]. Otherwise colour stays 0.
- ADVANCE (1 cycle):
  - If all 5 greens are set: go to WON, game_won = 1.
  - Else if row == MAX_ROWS-1: go to LOST, game_lost = 1.
  - Else row += 1, col = 0, go to ENTRY.
  - busy drops with the transition.
- Latency: enter accepted at cycle 0; greens visible at cycle 1; final colours at cycle 6; busy low from cycle 7.
- WON / LOST: all keys ignored, board frozen. Only new_game or clr leaves these states.
- Keys arriving while busy = 1 are dropped, not queued.
- display is a registered output and changes only on dclk edges.

Optional Feature:
- Macro: WORDLE_INVALID_FLASH_EN.
- Defined: key_enter with col < 5 in ENTRY paints colour 3 (red) on all 5 cells of the current row, letters kept. The next accepted key_valid or key_bksp first restores colour 0 on the row, then applies its own effect in the same cycle. new_game also clears the red.
- Undefined: key_enter with col < 5 is ignored and colours are untouched.

Test Plan:
- Reset, then new_game with target CRANE, type C,R,A,N,E, enter -> row 0 all colour 1; game_won=1 at cycle 7 after enter; busy high for cycles 1..6.
- Target ABBEY, guess BABES -> colours {2,2,1,1,0}; row advances to 1, col=0.
- Target ALLOW, guess LLAMA -> colours {2,1,2,0,0}; duplicate limits respected.
- Type X,Y, backspace x3, then letter Q -> cell(0,0)=Q, cell(0,1) blank, col=1. Key_code 30 -> ignored. Sixth letter after 5 -> ignored.
- Six wrong guesses with MAX_ROWS=6 -> game_lost=1 after the last ADVANCE; later letters leave display unchanged; new_game clears everything to blank/gray.
- Enter after 3 letters -> with WORDLE_INVALID_FLASH_EN, row 0 colour 3 until the next letter, then colour 0 plus the new letter. Without the macro, no change. Also assert clr mid-YELLOW -> board blank immediately, busy=0.
